// File: rtl/instr_fetch_unit_pkg.sv
// riscv_fetch_pkg: shared widths, halt word and fetch types for the instruction fetch slice.
package riscv_fetch_pkg;
   localparam int INSTR_WIDTH = 32;
   localparam int XLEN = 32;
   localparam logic [INSTR_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_HALTED} fetch_state_e;
   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fetch_pkt_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_if: bundle between fetch unit, instruction ROM, branch redirect and decode handshake.
interface instr_fetch_if import riscv_fetch_pkg::*; #(parameter int ADDR_WIDTH = 10);
   logic                   fetch_en;
   logic [ADDR_WIDTH-1:0]  imem_addr;
   logic [INSTR_WIDTH-1:0] imem_instr;
   logic                   redirect_valid;
   logic [XLEN-1:0]        redirect_pc;
   logic                   out_valid;
   logic                   out_ready;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic [XLEN-1:0]        out_pc;
   logic                   halted;
   modport master (
      input  fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
      output imem_addr, out_valid, out_instr, out_pc, halted
   );
   modport slave (
      output fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
      input  imem_addr, out_valid, out_instr, out_pc, halted
   );
endinterface

// File: rtl/instr_fetch_unit_out_reg.sv
// fetch_out_reg: one-entry valid/ready holding register for fetched packets; flush wins over everything.
module fetch_out_reg import riscv_fetch_pkg::*; (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       flush,
   input  logic       ready,
   input  fetch_pkt_t pkt_in,
   output logic       valid,
   output fetch_pkt_t pkt_out
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid   <= 1'b0;
         pkt_out <= '0;
      end else begin
         valid <= flush ? 1'b0 : load ? 1'b1 : ready ? 1'b0 : valid;
         if (load) pkt_out <= pkt_in;
      end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC/FSM owner driving the combinational instruction ROM and feeding decode.
// Optional halt-on-HALT_WORD support is enabled by defining IFETCH_HALT_EN.
module instr_fetch_unit import riscv_fetch_pkg::*; #(
   parameter int              IMEM_DEPTH_WORDS = 1024,
   parameter logic [XLEN-1:0] RESET_PC         = RESET_PC_DEFAULT
) (
   input logic           clk,
   input logic           rst_n,
   instr_fetch_if.master bus
);
   localparam int ADDR_WIDTH = $clog2(IMEM_DEPTH_WORDS);
   fetch_state_e    state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            load, halt_hit;
   fetch_pkt_t      pkt_in, pkt_out;
   assign load = state == FS_RUN && bus.fetch_en && (!bus.out_valid || bus.out_ready) && !bus.redirect_valid;
`ifdef IFETCH_HALT_EN
   assign halt_hit   = load && bus.imem_instr == HALT_WORD;
   assign bus.halted = state == FS_HALTED;
   // HALTED is sticky until a redirect; fetch_en is ignored meanwhile
   always_comb state_nxt = (state == FS_HALTED && !bus.redirect_valid) || halt_hit ? FS_HALTED :
                           bus.fetch_en ? FS_RUN : FS_IDLE;
`else
   assign halt_hit   = 1'b0;
   assign bus.halted = 1'b0;
   always_comb state_nxt = bus.fetch_en ? FS_RUN : FS_IDLE;
`endif
   // misaligned redirect targets silently lose their low bits
   always_comb pc_nxt = bus.redirect_valid ? bus.redirect_pc & ~32'd3 :
                        load && !halt_hit ? pc + 32'd4 : pc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= FS_IDLE;
         pc    <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
      end
   assign bus.imem_addr = pc[ADDR_WIDTH+1:2];
   assign pkt_in        = '{pc: pc, instr: bus.imem_instr};
   fetch_out_reg u_out (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .flush   (bus.redirect_valid),
      .ready   (bus.out_ready),
      .pkt_in  (pkt_in),
      .valid   (bus.out_valid),
      .pkt_out (pkt_out)
   );
   assign bus.out_pc    = pkt_out.pc;
   assign bus.out_instr = pkt_out.instr;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed + randomized bench; a stream-level model predicts the delivered instruction sequence.
module tb_instr_fetch_unit;
   import riscv_fetch_pkg::*;
   localparam int DEPTH = 1024;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] rom [DEPTH];
   int tests = 0;
   int fails = 0;
   int n_xfer = 0;
   fetch_pkt_t exp_q[$];
   logic [31:0] next_pc = 32'h0;
   bit stop = 1'b0;
   always #5 clk = ~clk;
   instr_fetch_if #(.ADDR_WIDTH(10)) bus ();
   assign bus.imem_instr = rom[bus.imem_addr];
   instr_fetch_unit #(.IMEM_DEPTH_WORDS(DEPTH), .RESET_PC(32'h0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // the decode-visible stream is sequential words from the last reset/redirect target, ending at a halt word when enabled
   function automatic void fill();
      while (!stop && exp_q.size() < 2) begin
         fetch_pkt_t p;
         p.pc = next_pc;
         p.instr = rom[(next_pc >> 2) % DEPTH];
         exp_q.push_back(p);
`ifdef IFETCH_HALT_EN
         if (p.instr == HALT_WORD) stop = 1'b1;
`endif
         next_pc = next_pc + 32'd4;
      end
   endfunction
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         next_pc = 32'h0;
         stop = 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            fill();
            if (exp_q.size() == 0) chk("xfer_after_halt", {31'b0, bus.out_valid}, 32'd0);
            else begin
               fetch_pkt_t p;
               p = exp_q.pop_front();
               chk("xfer_pc", bus.out_pc, p.pc);
               chk("xfer_instr", bus.out_instr, p.instr);
               n_xfer++;
            end
         end
         if (bus.redirect_valid) begin
            exp_q.delete();
            next_pc = bus.redirect_pc & ~32'd3;
            stop = 1'b0;
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         rom[i] = $urandom;
         if (rom[i] == HALT_WORD) rom[i] = 32'h1234_5678;
      end
      bus.fetch_en = 1'b0;
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      #1;
      chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_addr", {22'b0, bus.imem_addr}, 32'd0);
      chk("rst_pc", bus.out_pc, 32'd0);
      chk("rst_instr", bus.out_instr, 32'd0);
      chk("rst_halted", {31'b0, bus.halted}, 32'd0);
      step();
      step();
      #2 rst_n = 1'b1;
      step();
      bus.fetch_en = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("start_valid", {31'b0, bus.out_valid}, 32'd1);
         chk("start_pc", bus.out_pc, 32'(i * 4));
         chk("start_instr", bus.out_instr, rom[i]);
      end
      step();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_pc", bus.out_pc, 32'd8);
         chk("stall_instr", bus.out_instr, rom[2]);
         chk("stall_addr", {22'b0, bus.imem_addr}, 32'd3);
      end
      step();
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("unstall_hold_pc", bus.out_pc, 32'd8);
      @(negedge clk);
      chk("unstall_pc", bus.out_pc, 32'd12);
      chk("unstall_instr", bus.out_instr, rom[3]);
      step();
      bus.out_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h40;
      step();
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("redir_addr", {22'b0, bus.imem_addr}, 32'h10);
      @(negedge clk);
      chk("redir_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("redir_pc", bus.out_pc, 32'h40);
      chk("redir_instr", bus.out_instr, rom[16]);
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0000_0FFE;
      step();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("wrap_flush", {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk);
      chk("wrap_pc", bus.out_pc, 32'h0FFC);
      chk("wrap_instr", bus.out_instr, rom[1023]);
      chk("wrap_addr", {22'b0, bus.imem_addr}, 32'd0);
      @(negedge clk);
      chk("wrap2_pc", bus.out_pc, 32'h1000);
      chk("wrap2_instr", bus.out_instr, rom[0]);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("arst_pc", bus.out_pc, 32'd0);
      chk("arst_instr", bus.out_instr, 32'd0);
      chk("arst_addr", {22'b0, bus.imem_addr}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("restart_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("restart_pc", bus.out_pc, 32'd0);
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_n = ($urandom % 400) != 0;
         bus.fetch_en = ($urandom % 8) != 0;
         bus.out_ready = ($urandom % 4) != 0;
         bus.redirect_valid = ($urandom % 16) == 0;
         case ($urandom % 3)
            0: bus.redirect_pc = $urandom;
            1: bus.redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
            default: bus.redirect_pc = 32'h0000_0FF0 + ($urandom % 16);
         endcase
      end
      step();
      rst_n = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("xfer_count_min", {31'b0, n_xfer > 500}, 32'd1);
`ifdef IFETCH_HALT_EN
      step();
      rst_n = 1'b0;
      rom[2] = HALT_WORD;
      bus.fetch_en = 1'b1;
      step();
      rst_n = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_seq_pc", bus.out_pc, 32'(i * 4));
      end
      chk("halt_word", bus.out_instr, HALT_WORD);
      chk("halt_flag", {31'b0, bus.halted}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_drained", {31'b0, bus.out_valid}, 32'd0);
         chk("halt_addr", {22'b0, bus.imem_addr}, 32'd2);
      end
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc = 32'h0;
      step();
      bus.redirect_valid = 1'b0;
      @(negedge clk);
      chk("unhalt_flag", {31'b0, bus.halted}, 32'd0);
      @(negedge clk);
      chk("resume_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("resume_pc", bus.out_pc, 32'd0);
`else
      chk("halted_tied", {31'b0, bus.halted}, 32'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
